// File: rtl/mouse_pkg.sv
// mouse_pkg: shared state type, coordinate type and default visible-area limits
package mouse_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_PEND} mpos_state_t;
    typedef logic [11:0] coord_t;
    localparam coord_t X_MAX_DEF = 12'd1023;
    localparam coord_t Y_MAX_DEF = 12'd767;
endpackage

// File: rtl/mouse_pos_ctl_bit_sync.sv
// bit_sync: multi-flop synchroniser with synchronous reset, one chain per bit
module bit_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [STAGES-1:0][WIDTH-1:0] r_ff;
    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (rst) r_ff <= '0;
        else     r_ff <= {r_ff[STAGES-2:0], i_d};
    end
    assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/mouse_pos_ctl.sv
// mouse_pos_ctl: synchronise, debounce, clamp and vblank-commit mouse coordinates.
// Optional MOUSE_CLICK_EN adds a synchronised, debounced left-button click pulse.
module mouse_pos_ctl
    import mouse_pkg::*;
#(
    parameter coord_t X_MAX       = X_MAX_DEF,
    parameter coord_t Y_MAX       = Y_MAX_DEF,
    parameter int     SYNC_STAGES = 2,
    parameter int     STABLE_CYC  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        pos_upd,
    output logic        left_click
);
    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

    mpos_state_t   r_state, w_state_n;
    coord_t        w_sx, w_sy, w_cx, w_cy;
    logic [23:0]   w_smp, r_smp_d, r_raw_acc, r_cand, r_pos;
    logic [23:0]   w_raw_acc_n, w_cand_n, w_pos_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_vblnk_d, w_vb_rise, r_upd, w_upd_n;

    bit_sync #(.WIDTH(12), .STAGES(SYNC_STAGES)) u_sync_x (.clk(clk), .rst(rst), .i_d(mouse_xpos), .o_q(w_sx));
    bit_sync #(.WIDTH(12), .STAGES(SYNC_STAGES)) u_sync_y (.clk(clk), .rst(rst), .i_d(mouse_ypos), .o_q(w_sy));

    assign w_smp     = {w_sx, w_sy};
    assign w_cx      = (w_sx > X_MAX) ? X_MAX : w_sx;
    assign w_cy      = (w_sy > Y_MAX) ? Y_MAX : w_sy;
    assign w_vb_rise = vblnk & ~r_vblnk_d;

    // next-state: settle on any change, hold the candidate until vblank rises
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_raw_acc_n = r_raw_acc;
        w_cand_n    = r_cand;
        w_pos_n     = r_pos;
        w_upd_n     = 1'b0;
        case (r_state)
            S_IDLE: if (w_smp != r_raw_acc) begin
                w_state_n = S_SETTLE;
                w_cnt_n   = '0;
            end
            S_SETTLE: if (w_smp != r_smp_d) w_cnt_n = '0;
            else begin
                w_cnt_n = r_cnt + CW'(1);
                if (r_cnt == CW'(STABLE_CYC - 1)) begin
                    w_raw_acc_n = w_smp;
                    w_cand_n    = {w_cx, w_cy};
                    w_state_n   = S_PEND;
                end
            end
            S_PEND: if (w_vb_rise) begin
                w_pos_n   = r_cand;
                w_upd_n   = r_cand != r_pos;
                w_state_n = S_IDLE;
            end else if (w_smp != r_raw_acc) begin
                w_state_n = S_SETTLE;
                w_cnt_n   = '0;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_raw_acc <= '0;
            r_cand    <= '0;
            r_pos     <= '0;
            r_upd     <= 1'b0;
            r_smp_d   <= '0;
            r_vblnk_d <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_raw_acc <= w_raw_acc_n;
            r_cand    <= w_cand_n;
            r_pos     <= w_pos_n;
            r_upd     <= w_upd_n;
            r_smp_d   <= w_smp;
            r_vblnk_d <= vblnk;
        end
    end

    assign xpos    = r_pos[23:12];
    assign ypos    = r_pos[11:0];
    assign pos_upd = r_upd;

`ifdef MOUSE_CLICK_EN
    logic          w_left, r_left_d, r_btn_q, r_click;
    logic [CW-1:0] r_bcnt;

    bit_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_l (.clk(clk), .rst(rst), .i_d(mouse_left), .o_q(w_left));

    // debounce: button follows the synced input after STABLE_CYC equal samples; pulse on press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_d <= 1'b0;
            r_btn_q  <= 1'b0;
            r_click  <= 1'b0;
            r_bcnt   <= '0;
        end else begin
            r_left_d <= w_left;
            r_click  <= 1'b0;
            if (w_left != r_left_d) r_bcnt <= '0;
            else if (r_bcnt == CW'(STABLE_CYC - 1)) begin
                r_btn_q <= w_left;
                r_click <= w_left & ~r_btn_q;
            end else r_bcnt <= r_bcnt + CW'(1);
        end
    end

    assign left_click = r_click;
`else
    logic w_unused;
    assign w_unused   = mouse_left;
    assign left_click = 1'b0;
`endif
endmodule

// File: tb/tb_mouse_pos_ctl.sv
// tb_mouse_pos_ctl: directed self-checking bench for mouse_pos_ctl
module tb_mouse_pos_ctl;
    import mouse_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        mouse_left, vblnk;
    logic [11:0] xpos, ypos;
    logic        pos_upd, left_click;
    int          checks = 0;
    int          errors = 0;
    int          pulses;

    mouse_pos_ctl dut (
        .clk(clk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left), .vblnk(vblnk), .xpos(xpos), .ypos(ypos),
        .pos_upd(pos_upd), .left_click(left_click)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input string tag, input int ex, input int ey, input logic eu);
        vblnk = 1'b1;
        tick(1);
        chk({tag, "_x"}, 32'(xpos), 32'(ex));
        chk({tag, "_y"}, 32'(ypos), 32'(ey));
        chk({tag, "_upd"}, 32'(pos_upd), 32'(eu));
        tick(1);
        chk({tag, "_upd_off"}, 32'(pos_upd), 32'd0);
        tick(3);
        vblnk = 1'b0;
        tick(2);
    endtask

    task automatic count_clicks(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (left_click === 1'b1) pulses++;
        end
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0; mouse_xpos = 12'd0; mouse_ypos = 12'd0; mouse_left = 1'b0;
        tick(3);
        chk("rst_x", 32'(xpos), 32'd0);
        chk("rst_y", 32'(ypos), 32'd0);
        chk("rst_upd", 32'(pos_upd), 32'd0);
        chk("rst_click", 32'(left_click), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            vblnk = (k % 10) < 5;
            tick(1);
            chk("idle_upd", 32'(pos_upd), 32'd0);
        end
        vblnk = 1'b0;
        tick(2);
        chk("idle_x", 32'(xpos), 32'd0);
        mouse_xpos = 12'd300; mouse_ypos = 12'd200;
        tick(50);
        chk("hold_x", 32'(xpos), 32'd0);
        frame("basic", 300, 200, 1'b1);
        mouse_xpos = 12'd2000; mouse_ypos = 12'd900;
        tick(20);
        frame("clamp", 1023, 767, 1'b1);
        mouse_xpos = 12'd1500;
        tick(20);
        frame("clamp_eq", 1023, 767, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 20; k++) begin
                mouse_xpos = ((k / 2) % 2) ? 12'd101 : 12'd100;
                vblnk = (k >= 10) && (k < 15);
                tick(1);
                chk("toggle_x", 32'(xpos), 32'd1023);
                chk("toggle_upd", 32'(pos_upd), 32'd0);
            end
        end
        mouse_xpos = 12'd500; mouse_ypos = 12'd100;
        tick(20);
        mouse_xpos = 12'd400;
        vblnk = 1'b1;
        tick(1);
        chk("race_x", 32'(xpos), 32'd500);
        chk("race_y", 32'(ypos), 32'd100);
        chk("race_upd", 32'(pos_upd), 32'd1);
        tick(4);
        vblnk = 1'b0;
        tick(20);
        chk("race_hold_x", 32'(xpos), 32'd500);
        frame("race_next", 400, 100, 1'b1);
        pulses = 0;
        mouse_left = 1'b1;
        count_clicks(10);
        mouse_left = 1'b0;
        count_clicks(20);
`ifdef MOUSE_CLICK_EN
        chk("click_held", 32'(pulses), 32'd1);
`else
        chk("click_off", 32'(pulses), 32'd0);
`endif
        pulses = 0;
        mouse_left = 1'b1;
        count_clicks(2);
        mouse_left = 1'b0;
        count_clicks(20);
        chk("click_glitch", 32'(pulses), 32'd0);
        mouse_xpos = 12'd600;
        tick(4);
        chk("settle_state", 32'(dut.r_state), 32'(S_SETTLE));
        rst = 1'b1;
        tick(1);
        chk("mid_rst_x", 32'(xpos), 32'd0);
        chk("mid_rst_y", 32'(ypos), 32'd0);
        chk("mid_rst_upd", 32'(pos_upd), 32'd0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(S_IDLE));
        rst = 1'b0;
        tick(20);
        frame("after_rst", 600, 100, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
